// File: rtl/uart_stream_driver.sv
// Streams bytes from a small TX FIFO into a memory-mapped UART and drains
// received bytes, by polling the UART control register.
module uart_stream_driver #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_10MHz,
  input  logic        rst,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        busy_o,
  output logic        wr_po,
  output logic        reg_sel_po,
  output logic        addr_po,
  output logic [31:0] input_po,
  input  logic [31:0] output_pi
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    POLL, CHECK, WR_DATA, WR_SEND, RD_RX, CAP_RX, CLR_RX
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          wr_q, wr_d;
  logic          reg_sel_q, reg_sel_d;
  logic          addr_q, addr_d;
  logic [31:0]   input_q, input_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          send_seen_q, send_seen_d;

  logic full, empty, push, pop;
  logic unused_rd_bits;

  assign unused_rd_bits = &{1'b0, output_pi[31:8]};

  assign full       = (count_q == DEPTH_CNT);
  assign empty      = (count_q == '0);
  assign push       = tx_valid_i && !full;
  assign pop        = (state_q == WR_DATA);
  assign tx_ready_o = !full;

  assign wr_po      = wr_q;
  assign reg_sel_po = reg_sel_q;
  assign addr_po    = addr_q;
  assign input_po   = input_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = !empty || (state_q == WR_DATA) || (state_q == WR_SEND) || send_seen_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Bus outputs are computed for the state being entered, so they are registered.
  always_comb begin
    state_d     = state_q;
    wr_d        = 1'b0;
    reg_sel_d   = 1'b0;
    addr_d      = 1'b0;
    input_d     = 32'h0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    send_seen_d = send_seen_q;
    case (state_q)
      POLL: state_d = CHECK;
      CHECK: begin
        send_seen_d = output_pi[0];
        if (output_pi[1] && !output_pi[0]) begin
          state_d   = RD_RX;
          reg_sel_d = 1'b1;
          addr_d    = 1'b1;
        end else if (!output_pi[0] && !empty) begin
          state_d   = WR_DATA;
          wr_d      = 1'b1;
          reg_sel_d = 1'b1;
          input_d   = {24'h0, mem_q[rd_ptr_q]};
        end else begin
          state_d = POLL;
        end
      end
      WR_DATA: begin
        state_d = WR_SEND;
        wr_d    = 1'b1;
        input_d = 32'h1;
      end
      // The send bit was just written, so stay busy until CHECK sees it.
      WR_SEND: begin
        state_d     = POLL;
        send_seen_d = 1'b1;
      end
      RD_RX: begin
        state_d   = CAP_RX;
        reg_sel_d = 1'b1;
        addr_d    = 1'b1;
      end
      CAP_RX: begin
        state_d    = CLR_RX;
        rx_data_d  = output_pi[7:0];
        rx_valid_d = 1'b1;
        wr_d       = 1'b1;
      end
      CLR_RX:  state_d = POLL;
      default: state_d = POLL;
    endcase
  end

  always_ff @(posedge clk_10MHz or negedge rst) begin
    if (!rst) begin
      state_q     <= POLL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_q        <= 1'b0;
      reg_sel_q   <= 1'b0;
      addr_q      <= 1'b0;
      input_q     <= 32'h0;
      rx_data_q   <= 8'h0;
      rx_valid_q  <= 1'b0;
      send_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_q        <= wr_d;
      reg_sel_q   <= reg_sel_d;
      addr_q      <= addr_d;
      input_q     <= input_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      send_seen_q <= send_seen_d;
    end
  end

  always_ff @(posedge clk_10MHz) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

endmodule

// File: tb/tb_uart_stream_driver.sv
// Directed bench for uart_stream_driver with a small UART register model and
// scoreboard queues for expected register writes and received bytes.
module tb_uart_stream_driver;

   localparam int TX_CYCLES = 20;

   logic        clk_10MHz = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  tx_data_i;
   logic        tx_valid_i;
   logic        tx_ready_o;
   logic [7:0]  rx_data_o;
   logic        rx_valid_o;
   logic        busy_o;
   logic        wr_po;
   logic        reg_sel_po;
   logic        addr_po;
   logic [31:0] input_po;
   logic [31:0] output_pi;

   int checks_total = 0;
   int checks_passed = 0;
   logic [32:0] exp_wr_q[$];
   logic [7:0]  exp_rx_q[$];
   bit   mon_en = 1'b0;
   int   wr_count = 0;
   int   rd_count = 0;
   logic prev_rx_valid = 1'b0;

   logic       m_send = 1'b0;
   logic       m_new_rx = 1'b0;
   logic [7:0] m_tx_reg = 8'h0;
   logic [7:0] m_rx_reg = 8'h0;
   int         m_timer = 0;
   bit         hold_send;
   bit         loopback;
   bit         inj_req;
   logic [7:0] inj_data;

   uart_stream_driver #(.FIFO_DEPTH(4)) dut (
      .clk_10MHz (clk_10MHz),
      .rst       (rst),
      .tx_data_i (tx_data_i),
      .tx_valid_i(tx_valid_i),
      .tx_ready_o(tx_ready_o),
      .rx_data_o (rx_data_o),
      .rx_valid_o(rx_valid_o),
      .busy_o    (busy_o),
      .wr_po     (wr_po),
      .reg_sel_po(reg_sel_po),
      .addr_po   (addr_po),
      .input_po  (input_po),
      .output_pi (output_pi)
   );

   always #50 clk_10MHz = ~clk_10MHz;

   // UART register file as seen through the driver's read port.
   assign output_pi = !reg_sel_po ? {30'h0, m_new_rx, m_send}
                    : (addr_po ? {24'h0, m_rx_reg} : {24'h0, m_tx_reg});

   // UART model: send self-clears after TX_CYCLES unless held; loopback copies TX to RX.
   always @(posedge clk_10MHz) begin
      if (!rst) begin
         m_send <= 1'b0; m_new_rx <= 1'b0; m_tx_reg <= 8'h0; m_rx_reg <= 8'h0; m_timer <= 0;
      end else begin
         if (wr_po && !reg_sel_po) begin
            m_send   <= input_po[0];
            m_new_rx <= input_po[1];
            m_timer  <= TX_CYCLES;
         end else begin
            if (m_send && !hold_send) begin
               if (m_timer == 0) begin
                  m_send <= 1'b0;
                  if (loopback) begin
                     m_rx_reg <= m_tx_reg;
                     m_new_rx <= 1'b1;
                  end
               end else begin
                  m_timer <= m_timer - 1;
               end
            end
            if (inj_req) begin
               m_rx_reg <= inj_data;
               m_new_rx <= 1'b1;
            end
         end
         if (wr_po && reg_sel_po && !addr_po) m_tx_reg <= input_po[7:0];
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks_total++;
      assert (observed === expected) checks_passed++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic [7:0] data);
      @(negedge clk_10MHz);
      tx_data_i  = data;
      tx_valid_i = 1'b1;
      @(posedge clk_10MHz);
      #1 tx_valid_i = 1'b0;
   endtask

   task automatic injectRx(input logic [7:0] data);
      @(negedge clk_10MHz);
      inj_data = data;
      inj_req  = 1'b1;
      @(posedge clk_10MHz);
      #1 inj_req = 1'b0;
   endtask

   task automatic waitDrain(input string tag, input int maxCycles);
      int n = 0;
      while ((exp_wr_q.size() != 0 || exp_rx_q.size() != 0) && n < maxCycles) begin
         @(negedge clk_10MHz);
         n++;
      end
      #1 checkOutput(tag, 64'(exp_wr_q.size() + exp_rx_q.size()), 64'd0);
   endtask

   // Scoreboard: every write strobe and rx pulse is matched against the queues.
   always @(negedge clk_10MHz) begin
      if (rst) begin
         if (wr_po) wr_count++;
         if (reg_sel_po && addr_po) rd_count++;
         if (mon_en) begin
            if (wr_po) begin
               if (exp_wr_q.size() == 0) checkOutput("unexpected_write", 64'(exp_wr_q.size()), 64'd1);
               else checkOutput("reg_write", {addr_po, reg_sel_po, input_po}, {1'b0, exp_wr_q.pop_front()});
            end else begin
               checkOutput("idle_input_po", input_po, 64'd0);
            end
            if (rx_valid_o) begin
               checkOutput("rx_pulse_width", prev_rx_valid, 64'd0);
               if (exp_rx_q.size() == 0) checkOutput("unexpected_rx", 64'(exp_rx_q.size()), 64'd1);
               else checkOutput("rx_data", rx_data_o, exp_rx_q.pop_front());
            end
         end
         prev_rx_valid = rx_valid_o;
      end
   end

   initial begin
      int n;
      bit found;
      bit busy_gap;
      int start_wr;
      int rd_start;
      logic [7:0] bytes [5];
      bytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      tx_valid_i = 1'b0; tx_data_i = 8'h0;
      hold_send = 1'b0; loopback = 1'b0; inj_req = 1'b0; inj_data = 8'h0;

      repeat (2) @(negedge clk_10MHz);
      checkOutput("reset_wr", wr_po, 64'd0);
      checkOutput("reset_reg_sel", reg_sel_po, 64'd0);
      checkOutput("reset_addr", addr_po, 64'd0);
      checkOutput("reset_input", input_po, 64'd0);
      checkOutput("reset_rx_data", rx_data_o, 64'd0);
      checkOutput("reset_rx_valid", rx_valid_o, 64'd0);
      checkOutput("reset_busy", busy_o, 64'd0);
      checkOutput("reset_ready", tx_ready_o, 64'd1);
      rst = 1'b1;

      // Reset asserted while the data write is on the bus.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_10MHz);
         tx_data_i = 8'h11 * (i + 1);
         tx_valid_i = 1'b1;
         @(posedge clk_10MHz);
      end
      #1 tx_valid_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk_10MHz);
         if (wr_po && reg_sel_po) found = 1'b1;
      end
      checkOutput("rst_reach_wr_data", found, 64'd1);
      checkOutput("rst_wr_data_value", input_po, 64'h11);
      #5 rst = 1'b0;
      #1;
      checkOutput("rst_wr_drop", wr_po, 64'd0);
      checkOutput("rst_input_clear", input_po, 64'd0);
      checkOutput("rst_ready", tx_ready_o, 64'd1);
      checkOutput("rst_busy", busy_o, 64'd0);
      @(negedge clk_10MHz);
      @(negedge clk_10MHz);
      rst = 1'b1;
      start_wr = wr_count;
      repeat (40) @(negedge clk_10MHz);
      #1;
      checkOutput("rst_fifo_discarded", 64'(wr_count - start_wr), 64'd0);
      checkOutput("rst_busy_after", busy_o, 64'd0);
      checkOutput("rst_ready_after", tx_ready_o, 64'd1);

      mon_en = 1'b1;

      // Single byte: data write within three cycles, send write right after.
      exp_wr_q.push_back({1'b1, 32'hAA});
      exp_wr_q.push_back({1'b0, 32'h1});
      applyStimulus(8'hAA);
      found = 1'b0;
      for (int i = 0; i < 3 && !found; i++) begin
         @(negedge clk_10MHz);
         if (wr_po && reg_sel_po) found = 1'b1;
      end
      checkOutput("tx_latency", found, 64'd1);
      @(negedge clk_10MHz);
      checkOutput("send_follows_data", {wr_po, reg_sel_po, input_po}, {1'b1, 1'b0, 32'h1});
      busy_gap = 1'b0;
      n = 0;
      while (n < 200) begin
         @(negedge clk_10MHz);
         n++;
         if (!m_send) break;
         if (!busy_o) busy_gap = 1'b1;
      end
      checkOutput("busy_while_sending", busy_gap, 64'd0);
      checkOutput("tx_completed", m_send, 64'd0);
      repeat (4) @(negedge clk_10MHz);
      checkOutput("busy_idle", busy_o, 64'd0);
      waitDrain("single_tx_drain", 10);

      // FIFO full with send held high; fifth byte must be dropped.
      hold_send = 1'b1;
      exp_wr_q.push_back({1'b1, 32'h01});
      exp_wr_q.push_back({1'b0, 32'h1});
      applyStimulus(8'h01);
      waitDrain("preload_drain", 20);
      for (int i = 0; i < 4; i++) begin
         exp_wr_q.push_back({1'b1, 24'h0, bytes[i]});
         exp_wr_q.push_back({1'b0, 32'h1});
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_10MHz);
         checkOutput("ready_before_push", tx_ready_o, (i < 4) ? 64'd1 : 64'd0);
         tx_data_i = bytes[i];
         tx_valid_i = 1'b1;
         @(posedge clk_10MHz);
      end
      #1 tx_valid_i = 1'b0;
      checkOutput("ready_when_full", tx_ready_o, 64'd0);
      checkOutput("busy_when_full", busy_o, 64'd1);
      repeat (10) @(negedge clk_10MHz);
      checkOutput("no_write_while_send", 64'(exp_wr_q.size()), 64'd8);
      hold_send = 1'b0;
      waitDrain("fifo_full_drain", 400);
      repeat (40) @(negedge clk_10MHz);
      checkOutput("full_busy_after", busy_o, 64'd0);

      // Plain receive.
      exp_rx_q.push_back(8'h8C);
      exp_wr_q.push_back({1'b0, 32'h0});
      injectRx(8'h8C);
      waitDrain("rx_drain", 40);
      #1 checkOutput("rx_data_held", rx_data_o, 64'h8C);

      // RX arriving during a transmission waits, then beats the queued byte.
      hold_send = 1'b1;
      exp_wr_q.push_back({1'b1, 32'h5A});
      exp_wr_q.push_back({1'b0, 32'h1});
      applyStimulus(8'h5A);
      waitDrain("defer_tx_drain", 20);
      exp_rx_q.push_back(8'h3C);
      exp_wr_q.push_back({1'b0, 32'h0});
      exp_wr_q.push_back({1'b1, 32'h6B});
      exp_wr_q.push_back({1'b0, 32'h1});
      applyStimulus(8'h6B);
      injectRx(8'h3C);
      rd_start = rd_count;
      repeat (30) @(negedge clk_10MHz);
      #1;
      checkOutput("rx_deferred", 64'(rd_count - rd_start), 64'd0);
      checkOutput("rx_still_pending", m_new_rx, 64'd1);
      hold_send = 1'b0;
      waitDrain("defer_drain", 200);

      // Loopback: each transmitted byte comes back as a received byte.
      repeat (40) @(negedge clk_10MHz);
      loopback = 1'b1;
      exp_wr_q.push_back({1'b1, 32'hAA});
      exp_wr_q.push_back({1'b0, 32'h1});
      exp_wr_q.push_back({1'b0, 32'h0});
      exp_wr_q.push_back({1'b1, 32'h8C});
      exp_wr_q.push_back({1'b0, 32'h1});
      exp_wr_q.push_back({1'b0, 32'h0});
      exp_rx_q.push_back(8'hAA);
      exp_rx_q.push_back(8'h8C);
      applyStimulus(8'hAA);
      applyStimulus(8'h8C);
      waitDrain("loopback_drain", 300);
      loopback = 1'b0;
      repeat (10) @(negedge clk_10MHz);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/uart_stream_driver.md
UART_STREAM_DRIVER -- requirements
Module: uart_stream_driver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the number of TX byte-FIFO entries (power of two, at least 2).
REQ-002 SHALL have one clock; reset is asynchronous and active-low, with ports named clk_10MHz and rst.
REQ-003 SHALL have port clk_10MHz, input, 1 bit: system clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port tx_data_i, input, 8 bits: byte to transmit.
REQ-006 SHALL have port tx_valid_i, input, 1 bit: tx_data_i is valid this cycle.
REQ-007 SHALL have port tx_ready_o, output, 1 bit: FIFO not full; a byte is accepted when tx_valid_i and tx_ready_o are both high.
REQ-008 SHALL have port rx_data_o, output, 8 bits: last received byte; it holds its value until the next capture.
REQ-009 SHALL have port rx_valid_o, output, 1 bit: one-cycle pulse when rx_data_o is updated.
REQ-010 SHALL have port busy_o, output, 1 bit: TX work is pending or in flight.
REQ-011 SHALL have port wr_po, output, 1 bit: UART register write strobe.
REQ-012 SHALL have port reg_sel_po, output, 1 bit: UART register select (0 = control, 1 = data).
REQ-013 SHALL have port addr_po, output, 1 bit: data register address (0 = TX data, 1 = RX data).
REQ-014 SHALL have port input_po, output, 32 bits: UART register write data.
REQ-015 SHALL have port output_pi, input, 32 bits: UART register read data for the currently driven reg_sel_po/addr_po.

Function
REQ-016 SHALL use this UART control register layout: bit0 = send (set by the driver, cleared by the UART when TX is done); bit1 = new_rx (set by the UART when an RX byte arrives).
REQ-017 SHALL buffer TX bytes in a FIFO_DEPTH-entry circular FIFO with read and write pointers that wrap modulo FIFO_DEPTH; tx_ready_o = !full, computed combinationally.
REQ-018 SHALL accept no push when the FIFO is full, even if a pop occurs in the same cycle; push and pop in the same cycle when not full SHALL leave the occupancy unchanged.
REQ-019 SHALL implement an FSM with states POLL, CHECK, WR_DATA, WR_SEND, RD_RX, CAP_RX, CLR_RX.
REQ-020 SHALL, in POLL, drive reg_sel_po=0, addr_po=0, wr_po=0, then go to CHECK.
REQ-021 SHALL, in CHECK, sample output_pi and choose the next state by priority:
- new_rx=1 and send=0 -> RD_RX;
- send=0 and FIFO not empty -> WR_DATA;
- otherwise -> POLL.
REQ-022 SHALL, in WR_DATA, drive wr_po=1, reg_sel_po=1, addr_po=0, input_po={24'h0, FIFO head}, and pop the FIFO; next state WR_SEND.
REQ-023 SHALL, in WR_SEND, drive wr_po=1, reg_sel_po=0, addr_po=0, input_po=32'h1; next state POLL.
REQ-024 SHALL, in RD_RX, drive wr_po=0, reg_sel_po=1, addr_po=1; next state CAP_RX.
REQ-025 SHALL, in CAP_RX, register rx_data_o=output_pi[7:0] and pulse rx_valid_o for exactly one cycle; next state CLR_RX.
REQ-026 SHALL, in CLR_RX, drive wr_po=1, reg_sel_po=0, addr_po=0, input_po=32'h0 (clears new_rx; send is known to be 0); next state POLL.
REQ-027 SHALL assert wr_po only in WR_DATA, WR_SEND and CLR_RX, each time for exactly one cycle.
REQ-028 SHALL drive input_po=0 in every state that does not write.
REQ-029 SHALL, with the FSM in POLL, FIFO empty, the UART idle and a byte pushed at cycle N, assert the data write no later than cycle N+3 and the send write in the cycle after the data write.
REQ-030 SHALL defer RX service while send=1 and SHALL never write bit0=0 while a transmission is in progress.
REQ-031 SHALL drive busy_o = FIFO not empty, OR FSM in WR_DATA/WR_SEND, OR send=1 at the last CHECK.

Reset
REQ-032 SHALL, while rst=0 (asynchronously), force FSM=POLL, FIFO empty (pointers 0), wr_po=0, reg_sel_po=0, addr_po=0, input_po=0, rx_data_o=0, rx_valid_o=0, busy_o=0 and tx_ready_o=1.
REQ-033 SHALL, on reset asserted mid-write, drop wr_po in the same cycle and discard all queued bytes.

Verification
REQ-034 SHALL verify reset: assert rst=0 mid-WR_DATA -> wr_po=0 immediately, tx_ready_o=1, busy_o=0, FIFO empty after release.
REQ-035 SHALL verify single TX: push 8'hAA with the UART model idle -> data write with input_po=32'hAA at reg_sel 1/addr 0, then a write of 32'h1 at reg_sel 0, busy_o high until the model clears send.
REQ-036 SHALL verify FIFO full: push 5 bytes back-to-back while send=1 -> tx_ready_o=0 after 4 pushes, the 5th is dropped, bytes 1-4 are sent in order with wrap-around correct.
REQ-037 SHALL verify RX: the model sets new_rx with RX data 8'h8C -> one rx_valid_o pulse with rx_data_o=8'h8C, followed by a control write of 32'h0.
REQ-038 SHALL verify RX deferral: new_rx=1 while send=1 -> no RX read until send=0, then RX is serviced before the next queued TX byte.
REQ-039 SHALL verify loopback: tx connected to rx in the UART model, push 8'hAA then 8'h8C -> rx_valid_o pulses twice with 8'hAA then 8'h8C.
